// File: rtl/core_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_pkg -- shared encodings for the core's memory-side blocks.  Rev 1.0
// ----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_ACK    = 2'd2
    } arb_state_t;

    localparam logic       GNT_IF      = 1'b0;
    localparam logic       GNT_D       = 1'b1;
    localparam logic       MEM_WEN_OFF = 1'b1;
    localparam logic [3:0] BE_NONE     = 4'b0000;
    localparam logic [3:0] BE_WORD     = 4'b1111;

    // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
    function automatic logic pick_data(input logic if_req, input logic d_req,
                                       input logic last_grant);
        return d_req && (!if_req || (last_grant == GNT_IF));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_port_arbiter -- shares one single-ported memory between fetch and LSU.  Rev 1.0
// ----------------------------------------------------------------------------
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_do,
    output logic              busy,
    output logic              gnt_d
);

    localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("mem_port_arbiter: WAIT_CYCLES must be in 1..15");
    end

    arb_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_grant_q;
    logic              if_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_wen_q;
    logic [3:0]        mem_be_q;
    logic [DATA_W-1:0] mem_di_q;
    logic              busy_q;
    logic              grant_d;

    assign grant_d = pick_data(if_req, d_req, last_grant_q);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q      <= ARB_IDLE;
            cnt_q        <= '0;
            last_grant_q <= GNT_IF;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            mem_addr_q   <= '0;
            mem_wen_q    <= MEM_WEN_OFF;
            mem_be_q     <= BE_NONE;
            mem_di_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (if_req || d_req) begin
                        state_q      <= ARB_ACCESS;
                        cnt_q        <= CNT_LOAD;
                        busy_q       <= 1'b1;
                        last_grant_q <= grant_d;
                        if (grant_d == GNT_D) begin
                            mem_addr_q <= d_addr;
                            mem_be_q   <= d_be;
                            mem_di_q   <= d_wdata;
                            mem_wen_q  <= ~d_we;
                        end else begin
                            // Fetch is always a full-word read.
                            mem_addr_q <= if_addr;
                            mem_be_q   <= BE_WORD;
                            mem_di_q   <= '0;
                            mem_wen_q  <= MEM_WEN_OFF;
                        end
                    end
                end
                ARB_ACCESS: begin
                    if (cnt_q == '0) begin
                        if (last_grant_q == GNT_D) begin
                            d_rdata_q <= mem_do;
                            d_ack_q   <= 1'b1;
                        end else begin
                            if_rdata_q <= mem_do;
                            if_ack_q   <= 1'b1;
                        end
                        mem_wen_q <= MEM_WEN_OFF;
                        mem_be_q  <= BE_NONE;
                        state_q   <= ARB_ACK;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ARB_ACK: begin
                    // The idle cycle that follows keeps a requester dropping req on ack from being re-granted.
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign mem_addr = mem_addr_q;
    assign mem_wen  = mem_wen_q;
    assign mem_be   = mem_be_q;
    assign mem_di   = mem_di_q;
    assign busy     = busy_q;
    assign gnt_d    = last_grant_q;

endmodule
`default_nettype wire
